axi_sram_rd_arbiter: RTL and testbench
======================================

Name: axi_sram_rd_arbiter

Overview:
- Two-master read arbiter that shares the single AR/R port of the SRAM wrapper slave.
- M0 is the instruction-fetch master; M1 is the data master.
- One burst is in flight at a time. Round-robin grant is locked from AR acceptance until the last R beat.
- Sits between the masters' read channels and the SRAM wrapper's AR/R inputs.

Parameters:
ID_W, 4, master-side ID width; slave-side ID is ID_W+4 bits = {4-bit master tag, master ID}
ADDR_W, 32, address width
LEN_W, 4, burst length width
DATA_W, 32, data width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
Mx_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  master x (x=0,1) read address fields
Mx_ARVALID in 1 / Mx_ARREADY out 1  master x AR handshake
Mx_RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  master x read data fields
Mx_RVALID out 1 / Mx_RREADY in 1  master x R handshake
S_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID_W+4/ADDR_W/LEN_W/3/2  slave read address fields
S_ARVALID out 1 / S_ARREADY in 1  slave AR handshake
S_RID/RDATA/RRESP/RLAST  in  ID_W+4/DATA_W/2/1  slave read data fields
S_RVALID in 1 / S_RREADY out 1  slave R handshake

Behaviour:
- Reset (async, ARESETn=0):
  - state=IDLE, grant g=0, round-robin pointer ptr=0 (M0 favoured first), AR register cleared.
  - All outputs 0: ARREADYs, S_ARVALID, RVALIDs, S_RREADY, all field outputs.
  - Reset asserted mid-burst aborts the burst immediately; no beat is replayed.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner selection: only one ARVALID -> that master wins. Both -> master==ptr wins. Neither -> stay in IDLE.
  - Mx_ARREADY=1 combinationally for the winner only, and only in IDLE.
  - On the handshake: latch the winner's fields and set g=winner. S_ARID = {4'(g), Mx_ARID}. Next state = ADDR.
- ADDR:
  - S_ARVALID=1 from registers; fields held stable.
  - Both Mx_ARREADY=0.
  - S_ARREADY=1 -> DATA. Otherwise stay in ADDR; fields must not change.
  - Minimum latency: master AR handshake at cycle N -> S_ARVALID at N+1.
- DATA:
  - Granted master: Mx_RVALID=S_RVALID; Mx_RDATA/RRESP pass through; Mx_RID=S_RID[ID_W-1:0]; S_RREADY=Mx_RREADY. Pass-through is combinational, zero latency.
  - Non-granted master: RVALID=0, data outputs 0.
  - Exit on S_RVALID & S_RREADY & last -> IDLE, with ptr = ~g (the other master gets priority next).
  - Without the optional feature, last = S_RLAST.
  - A new AR can be accepted in the cycle after the last beat at the earliest; no AR is accepted during DATA.
- Boundary conditions:
  - S_RID tag not equal to g: the beat is still routed to g. Tag mismatch never deadlocks.
  - Mx_ARVALID dropped before grant: the request is simply not taken.
  - ARLEN=0 (single beat): ADDR -> DATA -> IDLE, normal path.
  - A master holding ARVALID continuously cannot starve the other: alternation is guaranteed when both request.
  - Mx_RREADY=0: S_RREADY=0 and slave back-pressure propagates; data must be held by the slave.

Optional Feature:
Macro: ARB_BEAT_CHECK_EN
- Defined:
  - A LEN_W+1 bit beat counter is cleared at ADDR->DATA and incremented on each R handshake.
  - last = (count == ARLEN latched).
  - Master RLAST is driven from the count, not from S_RLAST.
  - If S_RLAST differs from the count-based last on any beat, that beat's Mx_RRESP is forced to 2'b10 (SLVERR).
  - The burst ends on the count-based last. Any further slave beats arriving in IDLE are sunk: S_RREADY=1, no master RVALID.
- Undefined: no counter. RLAST and RRESP pass straight through; burst ends on S_RLAST.

Test Plan:
1. Single request: reset, M0 AR ADDR=0x100 LEN=3 ID=2 -> S_ARVALID next cycle with S_ARID=0x02; 4 beats routed to M0 with RID=2, RLAST on 4th; M1 RVALID=0 throughout.
2. Simultaneous request after reset: M0 and M1 both ARVALID -> M0 granted first; after its RLAST, M1 granted with S_ARID=0x1X; a third simultaneous pair is then granted to M0.
3. Back-pressure: S_ARREADY low 3 cycles -> S_ARVALID/fields stable; M1_RREADY low for 2 cycles mid-burst -> S_RREADY=0 in exactly those cycles, no beat lost.
4. Reset mid-burst: ARESETn=0 during beat 2 of LEN=7 -> all outputs 0 immediately; after release, M1 request is served normally, ptr back at 0.
5. ARB_BEAT_CHECK_EN: LEN=1, slave asserts S_RLAST on beat 1 -> Mx_RRESP=2'b10 on beat 1, master RLAST on beat 2, FSM returns to IDLE after beat 2.
6. Starvation: M0 ARVALID held high continuously, M1 requests once -> M1 granted right after the M0 burst in progress.

Source files
------------

// File: rtl/axi_sram_rd_arbiter_if.sv
// Read-only AXI channel bundle (AR + R) shared by the arbiter's master- and
// slave-facing ports. The slave-side instance is built with ID_W widened by
// the 4-bit master tag.
interface axi_sram_rd_arbiter_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    // Side that issues read requests and consumes read data
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Side that accepts read requests and returns read data
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_sram_rd_arbiter.sv
// Two-master read arbiter in front of the SRAM wrapper's single AR/R port.
// M0 = instruction fetch, M1 = data. One burst in flight; the grant is locked
// from AR acceptance until the final R beat, then priority flips to the other
// master so a continuously requesting master cannot starve its peer.
// Optional macro ARB_BEAT_CHECK_EN: count beats against the latched ARLEN,
// drive master RLAST from the count, flag S_RLAST disagreement as SLVERR and
// sink stray slave beats while idle.
module axi_sram_rd_arbiter #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_sram_rd_arbiter_if.slave  m0_if,
    axi_sram_rd_arbiter_if.slave  m1_if,
    axi_sram_rd_arbiter_if.master s_if
);

    localparam int unsigned TAG_W = 4;
    localparam int unsigned SID_W = ID_W + TAG_W;
`ifdef ARB_BEAT_CHECK_EN
    localparam int unsigned CNT_W = LEN_W + 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e            state_q;
    logic              g_q;
    logic              ptr_q;
    logic              arvalid_q;
    logic [SID_W-1:0]  arid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [LEN_W-1:0]  arlen_q;
    logic [2:0]        arsize_q;
    logic [1:0]        arburst_q;
`ifdef ARB_BEAT_CHECK_EN
    logic [CNT_W-1:0]  cnt_q;
`endif

    logic              win_c;
    logic              take_c;
    logic [ID_W-1:0]   win_id_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [LEN_W-1:0]  win_len_c;
    logic [2:0]        win_size_c;
    logic [1:0]        win_burst_c;

    logic              in_data_c;
    logic              sel0_c;
    logic              sel1_c;
    logic              sink_c;
    logic              rready_c;
    logic              r_hs_c;
    logic              last_c;
    logic              rlast_c;
    logic [1:0]        rresp_c;

    // Winner selection: lone requester wins, a tie goes to the pointer
    always_comb begin
        win_c       = 1'b0;
        take_c      = 1'b0;
        win_id_c    = m0_if.arid;
        win_addr_c  = m0_if.araddr;
        win_len_c   = m0_if.arlen;
        win_size_c  = m0_if.arsize;
        win_burst_c = m0_if.arburst;

        if (m0_if.arvalid && m1_if.arvalid) begin
            win_c = ptr_q;
        end else begin
            win_c = m1_if.arvalid;
        end

        // Reset gating keeps ARREADY low while ARESETn is asserted
        take_c = ARESETn && (state_q == ST_IDLE) && (m0_if.arvalid || m1_if.arvalid);

        if (win_c) begin
            win_id_c    = m1_if.arid;
            win_addr_c  = m1_if.araddr;
            win_len_c   = m1_if.arlen;
            win_size_c  = m1_if.arsize;
            win_burst_c = m1_if.arburst;
        end
    end

    // R-channel steering and end-of-burst detection
    always_comb begin
        in_data_c = (state_q == ST_DATA);
        sel0_c    = in_data_c && !g_q;
        sel1_c    = in_data_c && g_q;
`ifdef ARB_BEAT_CHECK_EN
        last_c    = (cnt_q == CNT_W'(arlen_q));
        rlast_c   = last_c;
        rresp_c   = (s_if.rlast != last_c) ? 2'b10 : s_if.rresp;
        // Stray beats after a count-terminated burst are drained while idle
        sink_c    = ARESETn && (state_q == ST_IDLE);
`else
        last_c    = s_if.rlast;
        rlast_c   = s_if.rlast;
        rresp_c   = s_if.rresp;
        sink_c    = 1'b0;
`endif
        if (in_data_c) begin
            rready_c = g_q ? m1_if.rready : m0_if.rready;
        end else begin
            rready_c = sink_c;
        end
        r_hs_c = s_if.rvalid && rready_c;
    end

    // Master AR handshake: only the winner, only while idle
    assign m0_if.arready = take_c && !win_c;
    assign m1_if.arready = take_c && win_c;

    // Master R outputs: granted master sees the slave, the other sees zeros
    assign m0_if.rvalid = sel0_c && s_if.rvalid;
    assign m0_if.rid    = sel0_c ? s_if.rid[ID_W-1:0] : '0;
    assign m0_if.rdata  = sel0_c ? s_if.rdata : '0;
    assign m0_if.rresp  = sel0_c ? rresp_c : 2'b00;
    assign m0_if.rlast  = sel0_c && rlast_c;

    assign m1_if.rvalid = sel1_c && s_if.rvalid;
    assign m1_if.rid    = sel1_c ? s_if.rid[ID_W-1:0] : '0;
    assign m1_if.rdata  = sel1_c ? s_if.rdata : '0;
    assign m1_if.rresp  = sel1_c ? rresp_c : 2'b00;
    assign m1_if.rlast  = sel1_c && rlast_c;

    // Slave AR is purely registered; R ready follows the granted master
    assign s_if.arvalid = arvalid_q;
    assign s_if.arid    = arid_q;
    assign s_if.araddr  = araddr_q;
    assign s_if.arlen   = arlen_q;
    assign s_if.arsize  = arsize_q;
    assign s_if.arburst = arburst_q;
    assign s_if.rready  = rready_c;

    // Arbitration FSM with latched AR payload and grant lock
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            g_q       <= 1'b0;
            ptr_q     <= 1'b0;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
`ifdef ARB_BEAT_CHECK_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_c) begin
                        arid_q    <= {TAG_W'(win_c), win_id_c};
                        araddr_q  <= win_addr_c;
                        arlen_q   <= win_len_c;
                        arsize_q  <= win_size_c;
                        arburst_q <= win_burst_c;
                        g_q       <= win_c;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_if.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
`ifdef ARB_BEAT_CHECK_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (r_hs_c) begin
`ifdef ARB_BEAT_CHECK_EN
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                        if (last_c) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= ~g_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_rd_arbiter.sv
// Scoreboard bench for axi_sram_rd_arbiter: directed requests push expected
// slave-side AR and per-master R beats; a monitor pops on every handshake.
module tb_axi_sram_rd_arbiter;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned SID_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
    } req_t;
    typedef logic [48:0] arexp_t;  // {arid, araddr, arlen, arsize, arburst}
    typedef logic [38:0] rexp_t;   // {rid, rdata, rresp, rlast}

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    axi_sram_rd_arbiter_if #(.ID_W(ID_W),  .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) m0_if ();
    axi_sram_rd_arbiter_if #(.ID_W(ID_W),  .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) m1_if ();
    axi_sram_rd_arbiter_if #(.ID_W(SID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) s_if ();

    axi_sram_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .m0_if   (m0_if),
        .m1_if   (m1_if),
        .s_if    (s_if)
    );

    // Master-side drive variables
    logic        m0_arvalid, m1_arvalid;
    logic [3:0]  m0_arid, m1_arid;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arlen, m1_arlen;
    logic        m0_rready, m1_rready;

    assign m0_if.arvalid = m0_arvalid;
    assign m0_if.arid    = m0_arid;
    assign m0_if.araddr  = m0_araddr;
    assign m0_if.arlen   = m0_arlen;
    assign m0_if.arsize  = 3'd2;
    assign m0_if.arburst = 2'b01;
    assign m0_if.rready  = m0_rready;
    assign m1_if.arvalid = m1_arvalid;
    assign m1_if.arid    = m1_arid;
    assign m1_if.araddr  = m1_araddr;
    assign m1_if.arlen   = m1_arlen;
    assign m1_if.arsize  = 3'd2;
    assign m1_if.arburst = 2'b01;
    assign m1_if.rready  = m1_rready;

    // Slave model drive variables
    logic        sl_arready, sl_rvalid, sl_rlast;
    logic [7:0]  sl_rid;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rresp;
    logic        sl_busy;

    assign s_if.arready = sl_arready;
    assign s_if.rvalid  = sl_rvalid;
    assign s_if.rid     = sl_rid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.rresp   = sl_rresp;
    assign s_if.rlast   = sl_rlast;

    // Slave behaviour knobs
    int   ar_delay;
    int   early_last;
    logic tag_flip;

    req_t   req0_q[$];
    req_t   req1_q[$];
    arexp_t exp_ar[$];
    rexp_t  exp_r0[$];
    rexp_t  exp_r1[$];

    int checks   = 0;
    int failures = 0;
    int rbeats0  = 0;
    int rbeats1  = 0;

    function automatic logic [31:0] bd(input logic [31:0] a, input int b);
        return a + 32'(b) * 32'h10 + 32'hA500_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // Queue a master request and, optionally, its expected R beats
    task automatic req(input int m, input logic [3:0] id, input logic [31:0] a, input int len, input bit push_r);
        req_t r;
        rexp_t e;
        r.id = id;
        r.addr = a;
        r.len = 4'(len);
        if (m == 0) req0_q.push_back(r);
        else        req1_q.push_back(r);
        if (push_r) begin
            for (int b = 0; b <= len; b++) begin
                e = {id, bd(a, b), 2'b00, (b == len)};
                if (m == 0) exp_r0.push_back(e);
                else        exp_r1.push_back(e);
            end
        end
    endtask

    task automatic ar(input int m, input logic [3:0] id, input logic [31:0] a, input int len);
        exp_ar.push_back({4'(m), id, a, 4'(len), 3'd2, 2'b01});
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge ACLK);
            if (exp_ar.size() == 0 && exp_r0.size() == 0 && exp_r1.size() == 0 &&
                req0_q.size() == 0 && req1_q.size() == 0 && !sl_busy && !m0_arvalid && !m1_arvalid)
                done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic wait_arhs(input int m, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge ACLK);
            if (m == 0) found = m0_arvalid && m0_if.arready;
            else        found = m1_arvalid && m1_if.arready;
        end
        if (!found) fail_now("arhs_timeout");
    endtask

    // Master 0 AR driver: holds ARVALID until accepted, back-to-back if queued
    initial begin
        req_t r;
        logic hs;
        m0_arvalid = 1'b0; m0_arid = '0; m0_araddr = '0; m0_arlen = '0;
        forever begin
            @(negedge ACLK);
            hs = m0_arvalid && m0_if.arready;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                m0_arvalid = 1'b0;
            end else begin
                if (hs) m0_arvalid = 1'b0;
                if (!m0_arvalid && req0_q.size() > 0) begin
                    r = req0_q.pop_front();
                    m0_arid = r.id; m0_araddr = r.addr; m0_arlen = r.len; m0_arvalid = 1'b1;
                end
            end
        end
    end

    // Master 1 AR driver
    initial begin
        req_t r;
        logic hs;
        m1_arvalid = 1'b0; m1_arid = '0; m1_araddr = '0; m1_arlen = '0;
        forever begin
            @(negedge ACLK);
            hs = m1_arvalid && m1_if.arready;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                m1_arvalid = 1'b0;
            end else begin
                if (hs) m1_arvalid = 1'b0;
                if (!m1_arvalid && req1_q.size() > 0) begin
                    r = req1_q.pop_front();
                    m1_arid = r.id; m1_araddr = r.addr; m1_arlen = r.len; m1_arvalid = 1'b1;
                end
            end
        end
    end

    // SRAM slave model: optional AR stall, len+1 beats, holds beats under back-pressure
    initial begin
        logic        arv, ar_hs, r_hs;
        logic [7:0]  cap_id, sl_id;
        logic [31:0] cap_addr, sl_addr;
        int          cap_len, sl_len, sl_beat, ar_cnt;
        sl_arready = 1'b0; sl_rvalid = 1'b0; sl_rlast = 1'b0; sl_rid = '0; sl_rdata = '0; sl_rresp = '0;
        sl_busy = 1'b0; ar_cnt = 0; sl_beat = 0; sl_len = 0; sl_id = '0; sl_addr = '0;
        cap_id = '0; cap_addr = '0; cap_len = 0;
        forever begin
            @(negedge ACLK);
            arv   = s_if.arvalid;
            ar_hs = arv && sl_arready;
            r_hs  = sl_rvalid && s_if.rready;
            if (ar_hs) begin
                cap_id = s_if.arid; cap_addr = s_if.araddr; cap_len = int'(s_if.arlen);
            end
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                sl_arready = 1'b0; sl_rvalid = 1'b0; sl_rlast = 1'b0; sl_busy = 1'b0; ar_cnt = 0;
            end else begin
                if (sl_busy && r_hs) begin
                    sl_beat++;
                    if (sl_beat > sl_len) sl_busy = 1'b0;
                end
                if (ar_hs) begin
                    sl_arready = 1'b0; sl_busy = 1'b1; sl_beat = 0;
                    sl_id = cap_id; sl_addr = cap_addr; sl_len = cap_len; ar_cnt = 0;
                end else if (!sl_busy && arv && !sl_arready) begin
                    if (ar_cnt >= ar_delay) sl_arready = 1'b1;
                    else ar_cnt++;
                end
                if (sl_busy) begin
                    sl_rvalid = 1'b1;
                    sl_rid    = sl_id ^ (tag_flip ? 8'h10 : 8'h00);
                    sl_rdata  = bd(sl_addr, sl_beat);
                    sl_rresp  = 2'b00;
                    sl_rlast  = (sl_beat == sl_len) || (sl_beat == early_last);
                end else begin
                    sl_rvalid = 1'b0;
                    sl_rlast  = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on handshakes plus AR-hold and R-exclusivity checks
    initial begin
        logic   prev_stall;
        arexp_t prev_ar, cur_ar;
        prev_stall = 1'b0;
        prev_ar = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                prev_stall = 1'b0;
            end else begin
                cur_ar = {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst};
                if (prev_stall)
                    chk("ar_hold", 64'({s_if.arvalid, cur_ar}), 64'({1'b1, prev_ar}));
                prev_stall = s_if.arvalid && !s_if.arready;
                prev_ar    = cur_ar;
                if (s_if.arvalid && s_if.arready) begin
                    if (exp_ar.size() == 0) fail_now("ar_unexpected");
                    else chk("ar_fields", 64'(cur_ar), 64'(exp_ar.pop_front()));
                end
                if (m0_if.rvalid && m0_if.rready) begin
                    rbeats0++;
                    if (exp_r0.size() == 0) fail_now("r0_unexpected");
                    else chk("r0_beat", 64'({m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast}), 64'(exp_r0.pop_front()));
                end
                if (m1_if.rvalid && m1_if.rready) begin
                    rbeats1++;
                    if (exp_r1.size() == 0) fail_now("r1_unexpected");
                    else chk("r1_beat", 64'({m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast}), 64'(exp_r1.pop_front()));
                end
                if (m0_if.rvalid || m1_if.rvalid)
                    chk("r_exclusive", 64'(m0_if.rvalid && m1_if.rvalid), 64'(0));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready,
                                 m0_if.rvalid, m1_if.rvalid, m0_if.rlast, m1_if.rlast}), 64'(0));
        chk({tag, "_ar"}, 64'({s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst}), 64'(0));
        chk({tag, "_r"}, 64'({m0_if.rdata, m1_if.rdata}), 64'(0));
        chk({tag, "_rid"}, 64'({m0_if.rid, m1_if.rid, m0_if.rresp, m1_if.rresp}), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        bit found;
        int base;
        ARESETn = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        ar_delay = 0; early_last = -1; tag_flip = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_all_zero("reset");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Simultaneous pair after reset: M0 first, then M1; next pair M0 again
        req(0, 4'h5, 32'h0000_0200, 1, 1'b1);
        req(1, 4'hA, 32'h0000_0300, 2, 1'b1);
        ar(0, 4'h5, 32'h0000_0200, 1);
        ar(1, 4'hA, 32'h0000_0300, 2);
        wait_drain(200);
        req(0, 4'h6, 32'h0000_0400, 0, 1'b1);
        req(1, 4'h3, 32'h0000_0500, 0, 1'b1);
        ar(0, 4'h6, 32'h0000_0400, 0);
        ar(1, 4'h3, 32'h0000_0500, 0);
        wait_drain(200);

        // Single M0 request, AR latency of one cycle, S_ARID = {tag 0, id 2}
        req(0, 4'h2, 32'h0000_0100, 3, 1'b1);
        ar(0, 4'h2, 32'h0000_0100, 3);
        wait_arhs(0, found);
        if (found) begin
            chk("lat_pre_arvalid", 64'(s_if.arvalid), 64'(0));
            @(negedge ACLK);
            chk("lat_arvalid", 64'(s_if.arvalid), 64'(1));
            chk("lat_arid", 64'(s_if.arid), 64'(8'h02));
        end
        wait_drain(200);

        // Slave returns the wrong tag: beats still routed to M0
        tag_flip = 1'b1;
        req(0, 4'h9, 32'h0000_0180, 1, 1'b1);
        ar(0, 4'h9, 32'h0000_0180, 1);
        wait_drain(200);
        tag_flip = 1'b0;

        // AR stall of several cycles, then M1 back-pressure mid-burst
        ar_delay = 3;
        base = rbeats1;
        req(1, 4'h7, 32'h0000_0600, 4, 1'b1);
        ar(1, 4'h7, 32'h0000_0600, 4);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge ACLK);
            found = (rbeats1 - base) >= 2;
        end
        if (!found) fail_now("bp_timeout");
        @(posedge ACLK); #1;
        m1_rready = 1'b0;
        @(negedge ACLK);
        chk("bp_cycle1", 64'({s_if.rready, m1_if.rvalid}), 64'(2'b01));
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("bp_cycle2", 64'({s_if.rready, m1_if.rvalid}), 64'(2'b01));
        @(posedge ACLK); #1;
        m1_rready = 1'b1;
        @(negedge ACLK);
        chk("bp_release", 64'({s_if.rready, m1_if.rvalid}), 64'(2'b11));
        wait_drain(200);
        ar_delay = 0;

`ifdef ARB_BEAT_CHECK_EN
        // Early S_RLAST on beat 1 of a 2-beat burst: SLVERR, RLAST from count
        early_last = 0;
        req(0, 4'h4, 32'h0000_0800, 1, 1'b0);
        exp_r0.push_back({4'h4, bd(32'h0000_0800, 0), 2'b10, 1'b0});
        exp_r0.push_back({4'h4, bd(32'h0000_0800, 1), 2'b00, 1'b1});
        ar(0, 4'h4, 32'h0000_0800, 1);
        wait_drain(200);
        early_last = -1;
`endif

        // Starvation: M0 keeps ARVALID high, M1 gets the next grant
        req(0, 4'h1, 32'h0000_0A00, 2, 1'b1);
        req(0, 4'h2, 32'h0000_0A40, 1, 1'b1);
        req(0, 4'h3, 32'h0000_0A80, 0, 1'b1);
        ar(0, 4'h1, 32'h0000_0A00, 2);
        wait_arhs(0, found);
        req(1, 4'h5, 32'h0000_0B00, 1, 1'b1);
        ar(1, 4'h5, 32'h0000_0B00, 1);
        ar(0, 4'h2, 32'h0000_0A40, 1);
        ar(0, 4'h3, 32'h0000_0A80, 0);
        wait_drain(300);

        // Reset mid-burst: leave ptr at 1 first, then abort an 8-beat M0 burst
        req(0, 4'h1, 32'h0000_0900, 0, 1'b1);
        ar(0, 4'h1, 32'h0000_0900, 0);
        wait_drain(200);
        base = rbeats0;
        req(0, 4'h2, 32'h0000_0C00, 7, 1'b1);
        ar(0, 4'h2, 32'h0000_0C00, 7);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge ACLK);
            found = (rbeats0 - base) >= 1;
        end
        if (!found) fail_now("midrst_timeout");
        @(posedge ACLK); #2;
        ARESETn = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_r0.delete();
        exp_ar.delete();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        req(0, 4'h6, 32'h0000_0D00, 1, 1'b1);
        req(1, 4'h9, 32'h0000_0D40, 0, 1'b1);
        ar(0, 4'h6, 32'h0000_0D00, 1);
        ar(1, 4'h9, 32'h0000_0D40, 0);
        wait_drain(200);

        repeat (3) @(negedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
